// File: rtl/siphash_unround.sv
// ============================================================================
// siphash_unround : iterative inverse-SipRound engine, one round per clock,
//                   valid/ready job in, valid/ready result out.
// Optional macro SIPHASH_UNROUND_FWD_EN adds in_fwd to select forward rounds.
// Revision: 1.0
// ============================================================================
`default_nettype none

module siphash_unround #(
    parameter int RCNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RCNT_W-1:0] in_rounds,
    input  logic [63:0]       iv0,
    input  logic [63:0]       iv1,
    input  logic [63:0]       iv2,
    input  logic [63:0]       iv3,
`ifdef SIPHASH_UNROUND_FWD_EN
    input  logic              in_fwd,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       ov0,
    output logic [63:0]       ov1,
    output logic [63:0]       ov2,
    output logic [63:0]       ov3,
    output logic              busy
);

    typedef logic [3:0][63:0] state_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t              fsm;
    state_t            s;
    state_t            ov_q;
    logic [RCNT_W-1:0] cnt;
    state_t            step;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Undo the forward round step by step, last operation first.
    function automatic state_t inv_round(input state_t o);
        logic [63:0] a0, a1, a2, a3, t0, t1, t2, t3, r0, r1, r2, r3;
        a2 = rotr(o[2], 32);
        t1 = rotr(o[1] ^ a2, 17);
        a3 = o[0];
        t3 = rotr(o[3] ^ a3, 21);
        t2 = a2 - t1;
        t0 = a3 - t3;
        a0 = rotr(t0, 32);
        a1 = t2;
        r1 = rotr(t1 ^ a0, 13);
        r3 = rotr(t3 ^ a1, 16);
        r0 = a0 - r1;
        r2 = a1 - r3;
        return {r3, r2, r1, r0};
    endfunction

`ifdef SIPHASH_UNROUND_FWD_EN
    logic fwd;

    function automatic state_t fwd_round(input state_t v);
        logic [63:0] v0, v1, v2, v3;
        {v3, v2, v1, v0} = v;
        v0 = v0 + v1;
        v1 = rotr(v1, 51) ^ v0;
        v0 = rotr(v0, 32);
        v2 = v2 + v3;
        v3 = rotr(v3, 48) ^ v2;
        v0 = v0 + v3;
        v3 = rotr(v3, 43) ^ v0;
        v2 = v2 + v1;
        v1 = rotr(v1, 47) ^ v2;
        v2 = rotr(v2, 32);
        return {v3, v2, v1, v0};
    endfunction

    assign step = fwd ? fwd_round(s) : inv_round(s);
`else
    assign step = inv_round(s);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            s         <= '0;
            ov_q      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SIPHASH_UNROUND_FWD_EN
            fwd       <= 1'b0;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        s        <= {iv3, iv2, iv1, iv0};
                        cnt      <= in_rounds;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef SIPHASH_UNROUND_FWD_EN
                        fwd      <= in_fwd;
`endif
                        if (in_rounds == '0) begin
                            fsm       <= DONE;
                            out_valid <= 1'b1;
                            ov_q      <= {iv3, iv2, iv1, iv0};
                        end else begin
                            fsm <= RUN;
                        end
                    end
                end
                RUN: begin
                    s   <= step;
                    cnt <= cnt - 1'b1;
                    if (cnt == RCNT_W'(1)) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                        ov_q      <= step;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign ov0 = ov_q[0];
    assign ov1 = ov_q[1];
    assign ov2 = ov_q[2];
    assign ov3 = ov_q[3];

endmodule

`default_nettype wire

// File: tb/tb_siphash_unround.sv
// ============================================================================
// tb_siphash_unround : table-driven vectors plus handshake/reset sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_siphash_unround;

    typedef logic [3:0][63:0] st_t;
    typedef struct {
        logic [3:0] n;
        st_t        iv;
        st_t        ex;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_rounds = '0;
    logic [63:0] iv0 = '0, iv1 = '0, iv2 = '0, iv3 = '0;
    logic        in_fwd = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] ov0, ov1, ov2, ov3;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    siphash_unround #(.RCNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rounds (in_rounds),
        .iv0       (iv0),
        .iv1       (iv1),
        .iv2       (iv2),
        .iv3       (iv3),
`ifdef SIPHASH_UNROUND_FWD_EN
        .in_fwd    (in_fwd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ov0       (ov0),
        .ov1       (ov1),
        .ov2       (ov2),
        .ov3       (ov3),
        .busy      (busy)
    );

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    // Reference forward SipRound; inverse results are checked against it.
    function automatic st_t sipround(input st_t s);
        logic [63:0] v0, v1, v2, v3;
        v0 = s[0]; v1 = s[1]; v2 = s[2]; v3 = s[3];
        v0 = v0 + v1; v1 = rotl(v1, 13) ^ v0; v0 = rotl(v0, 32);
        v2 = v2 + v3; v3 = rotl(v3, 16) ^ v2;
        v0 = v0 + v3; v3 = rotl(v3, 21) ^ v0;
        v2 = v2 + v1; v1 = rotl(v1, 17) ^ v2; v2 = rotl(v2, 32);
        return {v3, v2, v1, v0};
    endfunction

    function automatic st_t sipround_n(input st_t s, input int n);
        st_t r = s;
        for (int i = 0; i < n; i++) r = sipround(r);
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic st_t ov_now();
        return {ov3, ov2, ov1, ov0};
    endfunction

    // Offer a job, scramble inputs after accept, wait for result and hand it off.
    task automatic run_job(input logic [3:0] n, input st_t s, input logic f,
                           output st_t res, output int lat);
        int g;
        @(negedge clk);
        {iv3, iv2, iv1, iv0} = s;
        in_rounds = n;
        in_fwd    = f;
        in_valid  = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check("accept_timeout", 256'(g), 256'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        {iv3, iv2, iv1, iv0} = ~s;
        in_rounds = ~n;
        in_fwd    = ~f;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = ov_now();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handoff_idle", {254'(0), out_valid, in_ready}, {254'(0), 1'b0, 1'b1});
    endtask

    vec_t tbl[7];
    st_t  res, res2, x;
    int   lat;

    initial begin
        tbl[0] = '{n: 4'd4, iv: '0, ex: '0};
        tbl[1] = '{n: 4'd1,
                   iv: {64'h0000000100000000, 64'h0000200100000000,
                        64'h0000000040022001, 64'h0000000100000000},
                   ex: {64'h0, 64'h0, 64'h1, 64'h0}};
        tbl[2] = '{n: 4'd0,
                   iv: {64'h2222222222222222, 64'h1111111111111111,
                        64'hFEDCBA9876543210, 64'h0123456789ABCDEF},
                   ex: {64'h2222222222222222, 64'h1111111111111111,
                        64'hFEDCBA9876543210, 64'h0123456789ABCDEF}};
        tbl[3] = '{n: 4'd2, iv: '0,
                   ex: {64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001,
                        64'h0F0F0F0F0F0F0F0F, 64'hDEADBEEFCAFEF00D}};
        tbl[4] = '{n: 4'd7, iv: '0,
                   ex: {64'h736f6d6570736575, 64'h646f72616e646f6d,
                        64'h6c7967656e657261, 64'h7465646279746573}};
        tbl[5] = '{n: 4'd15, iv: '0,
                   ex: {64'h0123456789ABCDEF, 64'h1111111111111111,
                        64'hFEDCBA9876543210, 64'h2222222222222222}};
        tbl[6] = '{n: 4'd15, iv: '0,
                   ex: {64'h8000000000000000, 64'h0, 64'h0, 64'h1}};
        for (int i = 3; i < 7; i++) tbl[i].iv = sipround_n(tbl[i].ex, int'(tbl[i].n));

        repeat (3) @(negedge clk);
        check("reset_outputs", {ov_now(), in_ready, out_valid, busy},
              {256'(0), 1'b1, 1'b0, 1'b0});
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i].n, tbl[i].iv, 1'b0, res, lat);
            check($sformatf("vec%0d_ov", i), res, tbl[i].ex);
            check($sformatf("vec%0d_latency", i), 256'(lat), 256'(int'(tbl[i].n) + 1));
        end

        // Backpressure: result held for 10 cycles while a second job waits.
        @(negedge clk);
        {iv3, iv2, iv1, iv0} = tbl[2].iv;
        in_rounds = 4'd0;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        {iv3, iv2, iv1, iv0} = tbl[4].ex;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d", i), {ov_now(), out_valid, in_ready, busy},
                  {tbl[2].iv, 1'b1, 1'b0, 1'b1});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_idle", {254'(0), out_valid, in_ready}, {254'(0), 1'b0, 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_job", {ov_now(), out_valid, busy}, {tbl[4].ex, 1'b1, 1'b1});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during the fifth RUN cycle of a 15-round job.
        @(negedge clk);
        {iv3, iv2, iv1, iv0} = tbl[5].iv;
        in_rounds = 4'd15;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_run_busy", {254'(0), busy, out_valid}, {254'(0), 1'b1, 1'b0});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_run_reset", {ov_now(), in_ready, out_valid, busy},
              {256'(0), 1'b1, 1'b0, 1'b0});
        run_job(tbl[6].n, tbl[6].iv, 1'b0, res, lat);
        check("after_reset_ov", res, tbl[6].ex);

`ifdef SIPHASH_UNROUND_FWD_EN
        run_job(4'd1, {64'h0, 64'h0, 64'h1, 64'h0}, 1'b1, res, lat);
        check("fwd_single_ov", res, tbl[1].iv);
        check("fwd_single_latency", 256'(lat), 256'(2));
        x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_job(4'd15, x, 1'b1, res, lat);
        check("fwd15_ov", res, sipround_n(x, 15));
        run_job(4'd15, res, 1'b0, res2, lat);
        check("roundtrip15", res2, x);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
